// File: rtl/mul_pkg.sv
// Shared types and helpers for the radix-4 Booth multiplier.
// Holds the FSM state encoding, Booth select codes and iteration-count helper.
package mul_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        EXEC = 2'b01,
        DONE = 2'b10
    } mul_state_e;

    typedef enum logic [2:0] {
        ZERO     = 3'd0,
        PLUS_M   = 3'd1,
        PLUS_2M  = 3'd2,
        MINUS_M  = 3'd3,
        MINUS_2M = 3'd4
    } booth_sel_e;

    // Two multiplier bits retire per iteration over a (width+2)-bit extended operand.
    function automatic int n_iter(input int width);
        return width / 2 + 1;
    endfunction

endpackage

// File: rtl/booth_r4_recode.sv
// Radix-4 Booth recoder: maps the {Q[1], Q[0], q_-1} window to a partial-product select.
module booth_r4_recode
    import mul_pkg::*;
(
    input  logic [2:0] window,
    output booth_sel_e sel
);

    // Booth digit lookup for the current 3-bit window.
    always_comb begin
        sel = ZERO;
        case (window)
            3'b000:  sel = ZERO;
            3'b001:  sel = PLUS_M;
            3'b010:  sel = PLUS_M;
            3'b011:  sel = PLUS_2M;
            3'b100:  sel = MINUS_2M;
            3'b101:  sel = MINUS_M;
            3'b110:  sel = MINUS_M;
            3'b111:  sel = ZERO;
            default: sel = ZERO;
        endcase
    end

endmodule

// File: rtl/booth_r4_multiplier.sv
// Sequential radix-4 Booth multiplier, signed or unsigned, two multiplier bits per clock.
// The result register holds the last product until the next completion, op_clear or reset.
module booth_r4_multiplier
    import mul_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               op_start,
    input  logic               op_clear,
    input  logic               signed_mode,
    input  logic [WIDTH-1:0]   multiplier,
    input  logic [WIDTH-1:0]   multiplicand,
    output logic               op_busy,
    output logic               op_done,
    output logic [2*WIDTH-1:0] result
);

    localparam int N_ITER = n_iter(WIDTH);
    localparam int CNT_W  = $clog2(N_ITER);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_ITER - 1);

    mul_state_e           state_r, state_s;
    logic [CNT_W-1:0]     cnt_r;
    logic [WIDTH+1:0]     a_r, q_r, m_r;
    logic                 qm1_r;
    logic                 busy_r, done_r;
    logic [2*WIDTH-1:0]   result_r;

    logic                 start_ok_s;
    logic [WIDTH+1:0]     ext_m_s, ext_q_s;
    booth_sel_e           sel_s;
    logic [WIDTH+2:0]     addend_s, sum_s;
    logic [WIDTH+1:0]     next_a_s, next_q_s;

    booth_r4_recode u_recode (
        .window ({q_r[1:0], qm1_r}),
        .sel    (sel_s)
    );

    // Start acceptance and operand extension (sign or zero) to WIDTH+2 bits.
    always_comb begin
        start_ok_s = op_start && ((state_r == IDLE) || (state_r == DONE));
        if (signed_mode) begin
            ext_m_s = {{2{multiplicand[WIDTH-1]}}, multiplicand};
            ext_q_s = {{2{multiplier[WIDTH-1]}}, multiplier};
        end else begin
            ext_m_s = {2'b00, multiplicand};
            ext_q_s = {2'b00, multiplier};
        end
    end

    // Partial-product add in WIDTH+3 bits, then arithmetic shift of {A, Q, q_-1} by two.
    always_comb begin
        addend_s = '0;
        case (sel_s)
            ZERO:     addend_s = '0;
            PLUS_M:   addend_s = {m_r[WIDTH+1], m_r};
            PLUS_2M:  addend_s = {m_r, 1'b0};
            MINUS_M:  addend_s = -{m_r[WIDTH+1], m_r};
            MINUS_2M: addend_s = -{m_r, 1'b0};
            default:  addend_s = '0;
        endcase
        sum_s    = {a_r[WIDTH+1], a_r} + addend_s;
        next_a_s = {sum_s[WIDTH+2], sum_s[WIDTH+2:2]};
        next_q_s = {sum_s[1:0], q_r[WIDTH+1:2]};
    end

    // Next-state logic; op_clear overrides any start request.
    always_comb begin
        state_s = state_r;
        if (op_clear) begin
            state_s = IDLE;
        end else begin
            case (state_r)
                IDLE: begin
                    if (op_start) state_s = EXEC;
                    else          state_s = IDLE;
                end
                EXEC: begin
                    if (cnt_r == LAST_CNT) state_s = DONE;
                    else                   state_s = EXEC;
                end
                DONE: begin
                    if (op_start) state_s = EXEC;
                    else          state_s = DONE;
                end
                default: state_s = IDLE;
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_r <= IDLE;
        else          state_r <= state_s;
    end

    // Datapath, counter and registered status/result outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            a_r      <= '0;
            q_r      <= '0;
            m_r      <= '0;
            qm1_r    <= 1'b0;
            cnt_r    <= '0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            result_r <= '0;
        end else if (op_clear) begin
            a_r      <= '0;
            q_r      <= '0;
            m_r      <= '0;
            qm1_r    <= 1'b0;
            cnt_r    <= '0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            result_r <= '0;
        end else if (start_ok_s) begin
            a_r    <= '0;
            q_r    <= ext_q_s;
            m_r    <= ext_m_s;
            qm1_r  <= 1'b0;
            cnt_r  <= '0;
            busy_r <= 1'b1;
            done_r <= 1'b0;
        end else if (state_r == EXEC) begin
            a_r   <= next_a_s;
            q_r   <= next_q_s;
            qm1_r <= q_r[1];
            cnt_r <= cnt_r + CNT_W'(1);
            if (cnt_r == LAST_CNT) begin
                // Low 2*WIDTH bits of the fully shifted {A, Q}.
                result_r <= {next_a_s[WIDTH-3:0], next_q_s};
                busy_r   <= 1'b0;
                done_r   <= 1'b1;
            end
        end
    end

    assign op_busy = busy_r;
    assign op_done = done_r;
    assign result  = result_r;

endmodule

// File: tb/tb_booth_r4_multiplier.sv
// Scoreboard bench for booth_r4_multiplier at WIDTH=32 and WIDTH=8.
module tb_booth_r4_multiplier;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n;
    logic        op_start32, op_clear32, signed32;
    logic [31:0] q32, m32;
    logic        busy32, done32;
    logic [63:0] res32;

    logic        op_start8, op_clear8, signed8;
    logic [7:0]  q8, m8;
    logic        busy8, done8;
    logic [15:0] res8;

    int vec_cnt = 0;
    int err_cnt = 0;
    logic [63:0] sb32[$];
    logic [15:0] sb8[$];
    logic [63:0] last32;

    booth_r4_multiplier #(.WIDTH(32)) dut32 (
        .clk(clk), .reset_n(reset_n), .op_start(op_start32), .op_clear(op_clear32),
        .signed_mode(signed32), .multiplier(q32), .multiplicand(m32),
        .op_busy(busy32), .op_done(done32), .result(res32)
    );

    booth_r4_multiplier #(.WIDTH(8)) dut8 (
        .clk(clk), .reset_n(reset_n), .op_start(op_start8), .op_clear(op_clear8),
        .signed_mode(signed8), .multiplier(q8), .multiplicand(m8),
        .op_busy(busy8), .op_done(done8), .result(res8)
    );

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vec_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] prod32(input logic [31:0] q, input logic [31:0] m, input logic s);
        logic signed [63:0] sq, sm;
        if (s) begin
            sq = $signed({{32{q[31]}}, q});
            sm = $signed({{32{m[31]}}, m});
            return sq * sm;
        end
        return {32'd0, q} * {32'd0, m};
    endfunction

    function automatic logic [15:0] prod8(input logic [7:0] q, input logic [7:0] m, input logic s);
        logic signed [15:0] sq, sm;
        if (s) begin
            sq = $signed({{8{q[7]}}, q});
            sm = $signed({{8{m[7]}}, m});
            return sq * sm;
        end
        return {8'd0, q} * {8'd0, m};
    endfunction

    task automatic start32(input logic [31:0] q, input logic [31:0] m, input logic s);
        q32 = q;
        m32 = m;
        signed32 = s;
        sb32.push_back(prod32(q, m, s));
        op_start32 = 1'b1;
        tick();
        op_start32 = 1'b0;
        check_val("start_busy", 64'(busy32), 64'd1);
        check_val("start_done_low", 64'(done32), 64'd0);
        check_val("start_hold", res32, last32);
    endtask

    // Waits for completion; inject >= 0 pulses a bogus start at that EXEC cycle.
    task automatic wait32(input int inject);
        int cyc = 0;
        int busy_n = 1;
        logic held = 1'b1;
        logic [63:0] exp;
        while (!done32 && cyc < 60) begin
            if (cyc == inject) begin
                q32 = ~q32;
                m32 = 32'h1234_5679;
                signed32 = ~signed32;
                op_start32 = 1'b1;
            end
            tick();
            op_start32 = 1'b0;
            cyc++;
            if (!done32) begin
                if (busy32) busy_n++;
                if (res32 !== last32) held = 1'b0;
            end
        end
        check_val("latency32", 64'(cyc), 64'd17);
        check_val("busy_cycles32", 64'(busy_n), 64'd17);
        check_val("result_held32", 64'(held), 64'd1);
        check_val("busy_low_done32", 64'(busy32), 64'd0);
        exp = (sb32.size() > 0) ? sb32.pop_front() : 64'hDEAD_DEAD_DEAD_DEAD;
        check_val("product32", res32, exp);
        last32 = exp;
    endtask

    task automatic run8(input logic [7:0] q, input logic [7:0] m, input logic s);
        int cyc = 0;
        logic [15:0] exp;
        q8 = q;
        m8 = m;
        signed8 = s;
        sb8.push_back(prod8(q, m, s));
        op_start8 = 1'b1;
        tick();
        op_start8 = 1'b0;
        while (!done8 && cyc < 30) begin
            tick();
            cyc++;
        end
        check_val("latency8", 64'(cyc), 64'd5);
        exp = (sb8.size() > 0) ? sb8.pop_front() : 16'hDEAD;
        check_val("product8", 64'(res8), 64'(exp));
    endtask

    logic [7:0] vals8 [16] = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h7F, 8'h80, 8'h81, 8'hFF,
                               8'hFE, 8'h55, 8'hAA, 8'h40, 8'hC0, 8'h7E, 8'h0F, 8'hF0};

    initial begin
        logic seen;
        reset_n = 1'b0;
        op_start32 = 1'b0; op_clear32 = 1'b0; signed32 = 1'b0; q32 = '0; m32 = '0;
        op_start8 = 1'b0;  op_clear8 = 1'b0;  signed8 = 1'b0;  q8 = '0;  m8 = '0;
        last32 = '0;
        tick();
        check_val("reset_busy", 64'(busy32), 64'd0);
        check_val("reset_done", 64'(done32), 64'd0);
        check_val("reset_result", res32, 64'd0);
        check_val("reset_result8", 64'(res8), 64'd0);
        tick();
        reset_n = 1'b1;
        tick();

        // Spec vectors, signed and unsigned.
        start32(32'hFFFF_FFFF, 32'h0000_0002, 1'b1);
        wait32(-1);
        check_val("neg1x2_signed", res32, 64'hFFFF_FFFF_FFFF_FFFE);
        start32(32'hFFFF_FFFF, 32'h0000_0002, 1'b0);
        wait32(-1);
        check_val("ffx2_unsigned", res32, 64'h0000_0001_FFFF_FFFE);
        start32(32'h8000_0000, 32'h8000_0000, 1'b1);
        wait32(-1);
        check_val("min_sq_signed", res32, 64'h4000_0000_0000_0000);
        start32(32'h8000_0000, 32'h8000_0000, 1'b0);
        wait32(-1);
        check_val("min_sq_unsigned", res32, 64'h4000_0000_0000_0000);

        // Abort mid-EXEC; the aborted product never appears.
        start32(32'd3, 32'd5, 1'b1);
        void'(sb32.pop_back());
        repeat (4) tick();
        op_clear32 = 1'b1;
        tick();
        op_clear32 = 1'b0;
        check_val("abort_busy", 64'(busy32), 64'd0);
        check_val("abort_result", res32, 64'd0);
        check_val("abort_done", 64'(done32), 64'd0);
        last32 = '0;
        seen = 1'b0;
        repeat (20) begin
            tick();
            if (done32) seen = 1'b1;
        end
        check_val("abort_no_done", 64'(seen), 64'd0);
        start32(32'd7, 32'd6, 1'b0);
        wait32(-1);
        check_val("after_abort", res32, 64'h2A);

        // Start pulse during EXEC is ignored; then back-to-back restart from DONE.
        start32(32'hDEAD_BEEF, 32'h0BAD_F00D, 1'b1);
        wait32(5);
        start32(32'h1234_5678, 32'h8765_4321, 1'b0);
        wait32(-1);

        // Asynchronous reset mid-EXEC.
        start32(32'hCAFE_0001, 32'h7FFF_FFFF, 1'b1);
        void'(sb32.pop_back());
        repeat (6) tick();
        #2 reset_n = 1'b0;
        #1;
        check_val("async_rst_busy", 64'(busy32), 64'd0);
        check_val("async_rst_done", 64'(done32), 64'd0);
        check_val("async_rst_result", res32, 64'd0);
        last32 = '0;
        tick();
        tick();
        reset_n = 1'b1;
        tick();
        start32(32'h7FFF_FFFF, 32'h8000_0001, 1'b1);
        wait32(-1);

        // Random 32-bit operations in both modes.
        for (int i = 0; i < 16; i++) begin
            start32($urandom, $urandom, 1'(i % 2));
            wait32(-1);
        end

        // WIDTH=8: corner-value cross product in both modes plus random pairs.
        for (int i = 0; i < 16; i++) begin
            for (int j = 0; j < 16; j++) begin
                run8(vals8[i], vals8[j], 1'b1);
                run8(vals8[i], vals8[j], 1'b0);
            end
        end
        for (int i = 0; i < 100; i++) begin
            run8(8'($urandom), 8'($urandom), 1'(i % 2));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
